// File: rtl/ucaspian_pkg.sv
// Shared types for the uCaspian synapse stage.
// Entry layout, FSM encoding and table size.
package ucaspian_pkg;

    localparam int SYN_COUNT = 4096;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_NEURON_W = 8;

    typedef struct packed {
        logic [DEF_WEIGHT_W-1:0] weight;
        logic [DEF_NEURON_W-1:0] target;
    } syn_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CLEAR
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Head word is presented combinationally on dout.
module sync_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp] <= din;
    end

endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse stage: walks an index range through the synapse RAM
// and emits (target, weight) events to the dendrite stage.
module ucaspian_synapse
    import ucaspian_pkg::*;
#(
    parameter int SYN_AW = 12,
    parameter int NEURON_W = 8,
    parameter int WEIGHT_W = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_config,
    output logic                clear_done,
    input  logic [SYN_AW-1:0]   config_addr,
    input  logic [7:0]          config_value,
    input  logic [2:0]          config_byte,
    input  logic                config_enable,
    input  logic                next_step,
    output logic                step_done,
    input  logic [SYN_AW-1:0]   syn_start,
    input  logic [SYN_AW-1:0]   syn_end,
    input  logic                syn_vld,
    output logic                syn_rdy,
    output logic [NEURON_W-1:0] dend_addr,
    output logic [WEIGHT_W-1:0] dend_weight,
    output logic                dend_vld,
    input  logic                dend_rdy
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int EW = WEIGHT_W + NEURON_W;

    state_t            state, state_nx;
    logic [SYN_AW-1:0] cur, end_idx, clr_addr;
    logic [7:0]        stg_weight;
    logic              rd_vld, xfer, issue;
    logic [EW-1:0]     mem [2**SYN_AW];
    logic [EW-1:0]     rd_data, wdata, fifo_dout;
    logic [SYN_AW-1:0] waddr;
    logic              clr_we, cfg_we, we;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occ;
    logic              fifo_empty, fifo_full;
    syn_entry_t        wr_ent;
    logic              unused_ok;

    assign unused_ok = next_step ^ fifo_full;

    assign xfer  = syn_vld && syn_rdy;
    assign occ   = {1'b0, fifo_count} + {{CW{1'b0}}, rd_vld};
    // Credit covers the read still in the RAM pipeline.
    assign issue = (state == S_ISSUE) && enable && !clear_config
                && (occ < (CW+1)'(OUT_DEPTH));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (xfer) state_nx = S_ISSUE;
            S_ISSUE: if (issue && cur == end_idx) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_IDLE;
            S_CLEAR: if (!clear_config) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clear_config) state_nx = S_CLEAR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cur       <= '0;
            end_idx   <= '0;
            syn_rdy   <= 1'b1;
            rd_vld    <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_vld <= issue;
            if (xfer) begin
                cur     <= syn_start;
                end_idx <= syn_end;
            end else if (issue) begin
                cur <= cur + 1'b1;
            end
            if (clear_config || xfer)
                syn_rdy <= 1'b0;
            else if (state != S_IDLE && state_nx == S_IDLE)
                syn_rdy <= 1'b1;
            step_done <= (state == S_IDLE) && !syn_vld && !rd_vld
                      && fifo_empty && !clear_config;
        end
    end

    // Config staging and the clear walker share the RAM write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_weight <= '0;
            clr_addr   <= '0;
            clear_done <= 1'b0;
        end else begin
            if (config_enable && !clear_config) begin
                if (config_byte == 3'd1) stg_weight <= '0;
                if (config_byte == 3'd2) stg_weight <= config_value;
            end
            if (!clear_config) begin
                clr_addr   <= '0;
                clear_done <= 1'b0;
            end else if (!clear_done) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == '1) clear_done <= 1'b1;
            end
        end
    end

    assign wr_ent = '{weight: stg_weight, target: config_value};
    assign clr_we = clear_config && !clear_done;
    assign cfg_we = config_enable && !clear_config && config_byte == 3'd3;
    assign we     = clr_we || cfg_we;
    assign waddr  = clr_we ? clr_addr : config_addr;
    assign wdata  = clr_we ? '0 : EW'(wr_ent);

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (issue) rd_data <= mem[cur];
    end

    sync_fifo #(
        .W     (EW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear_config),
        .push  (rd_vld && !clear_config),
        .din   (rd_data),
        .pop   (dend_rdy),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign dend_vld    = !fifo_empty;
    assign dend_addr   = fifo_dout[NEURON_W-1:0];
    assign dend_weight = fifo_dout[EW-1:NEURON_W];

endmodule
